// File: rtl/mxregs_ctx_pkg.sv
// mxregs_pkg: shared command/state encodings, register indices and load decode codes for mxregs_ctx
package mxregs_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_SWAP = 2'b11} ctx_op_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PUSH = 2'd1, ST_POP = 2'd2, ST_DONE = 2'd3} ctx_state_t;
  localparam int IDX_A     = 0;
  localparam int IDX_X     = 1;
  localparam int IDX_Y     = 2;
  localparam int IDX_D     = 3;
  localparam int IDX_B     = 4;
  localparam int IDX_C     = 5;
  localparam int IDX_INSP  = 6;
  localparam int IDX_FLAGS = 7;
  localparam int IDX_SA    = 8;
  localparam int IDX_SX    = 9;
  localparam int IDX_SY    = 10;
  localparam int IDX_SD    = 11;
  localparam int IDX_R0    = 12;
  localparam int IDX_R1    = 13;
  localparam int IDX_R2    = 14;
  localparam int IDX_R3    = 15;
  localparam logic [7:0] LD_FLAGS_A = 8'h10;
  localparam logic [7:0] LD_FLAGS_X = 8'h11;
  localparam logic [7:0] LD_FLAGS_Y = 8'h12;
  localparam logic [7:0] LD_FLAGS_D = 8'h13;
  localparam logic [7:0] LD_R2_INSP = 8'h80;
endpackage

// File: rtl/mxregs_ctx_stack.sv
// mxregs_ctx_stack: LIFO frame memory, one write port by frame/slot and a combinational read port
module mxregs_ctx_stack #(
  parameter int WORD_LENGTH = 8,
  parameter int CTX_REGS    = 8,
  parameter int CTX_DEPTH   = 4,
  parameter int FW          = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1,
  parameter int SW          = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [FW-1:0]          i_wr_frame,
  input  logic [SW-1:0]          i_wr_slot,
  input  logic [WORD_LENGTH-1:0] i_wdata,
  input  logic [FW-1:0]          i_rd_frame,
  input  logic [SW-1:0]          i_rd_slot,
  output logic [WORD_LENGTH-1:0] o_rdata
);
  logic [WORD_LENGTH-1:0] r_mem [CTX_DEPTH][CTX_REGS];
  // frame contents survive reset; only the level in the parent tracks validity
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wr_frame][i_wr_slot] <= i_wdata;
  assign o_rdata = r_mem[i_rd_frame][i_rd_slot];
endmodule

// File: rtl/mxregs_ctx.sv
// mxregs_ctx: register bank with load decoder and context stack; MXREGS_CTX_SWAP_EN enables SWAP with shadow regs 8..11
module mxregs_ctx
  import mxregs_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16,
  parameter int CTX_REGS    = 8,
  parameter int CTX_DEPTH   = 4,
  parameter int FLAGS_IDX   = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DEPTH*WORD_LENGTH-1:0]        data_line,
  input  logic [7:0]                          load_addr,
  input  logic                                load_en,
  output logic [DEPTH*WORD_LENGTH-1:0]        reg_line,
  input  logic                                ctx_req,
  input  logic [1:0]                          ctx_op,
  output logic                                ctx_busy,
  output logic                                ctx_ack,
  output logic                                ctx_err,
  output logic [$clog2(CTX_DEPTH+1)-1:0]      ctx_level
);
  localparam int LW = $clog2(CTX_DEPTH + 1);
  localparam int FW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
  localparam int SW = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1;
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_PUSH = ST_PUSH;
  localparam logic [1:0] S_POP  = ST_POP;
  localparam logic [1:0] S_DONE = ST_DONE;
  logic [1:0]             r_state;
  logic [SW-1:0]          r_idx;
  logic [LW-1:0]          r_level;
  logic                   r_err;
  logic [WORD_LENGTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]       w_dec;
  logic                   w_swap;
  logic                   w_last;
  logic [WORD_LENGTH-1:0] w_wdata;
  logic [WORD_LENGTH-1:0] w_rdata;
`ifdef MXREGS_CTX_SWAP_EN
  if (DEPTH < 12) begin : g_depth_chk
    $error("mxregs_ctx: SWAP needs DEPTH >= 12");
  end
  assign w_swap = (r_state == S_IDLE) && ctx_req && (ctx_op == OP_SWAP);
`else
  assign w_swap = 1'b0;
`endif
  assign w_last    = r_idx == SW'(CTX_REGS - 1);
  assign w_wdata   = r_regs[IW'(r_idx)];
  assign ctx_busy  = r_state != S_IDLE;
  assign ctx_ack   = r_state == S_DONE;
  assign ctx_err   = ctx_ack && r_err;
  assign ctx_level = r_level;
  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign reg_line[g*WORD_LENGTH +: WORD_LENGTH] = r_regs[g];
  end
  mxregs_ctx_stack #(
    .WORD_LENGTH(WORD_LENGTH), .CTX_REGS(CTX_REGS), .CTX_DEPTH(CTX_DEPTH)
  ) u_stack (
    .clk(clk),
    .i_we(r_state == S_PUSH),
    .i_wr_frame(r_level[FW-1:0]),
    .i_wr_slot(r_idx),
    .i_wdata(w_wdata),
    .i_rd_frame(FW'(r_level - 1'b1)),
    .i_rd_slot(r_idx),
    .o_rdata(w_rdata)
  );
  // load decoder: direct indices first, paired FLAGS codes and R2/INSP only above the direct range
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++)
      w_dec[i] = load_en && ((int'(load_addr) < DEPTH) ? int'(load_addr) == i :
        ((load_addr inside {[LD_FLAGS_A:LD_FLAGS_D]}) && (i == FLAGS_IDX || i == int'(load_addr) - 16)) ||
        (load_addr == LD_R2_INSP && DEPTH > 14 && (i == IDX_R2 || i == IDX_INSP)));
  end
  // register array: swap exchange, then pop restore, then decoded load in priority order
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (rst) r_regs[i] <= '0;
      else if (w_swap && (i < 4 || (i >= 8 && i < 12))) r_regs[i] <= r_regs[(i < 4) ? i + 8 : i - 8];
      else if (r_state == S_POP && i < CTX_REGS && r_idx == SW'(i)) r_regs[i] <= w_rdata;
      else if (w_dec[i]) r_regs[i] <= data_line[i*WORD_LENGTH +: WORD_LENGTH];
  // context FSM: one slot per cycle, rejected commands go straight to the ack state with err
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_level <= '0;
      r_err   <= 1'b0;
    end else case (r_state)
      S_IDLE: begin
        r_idx <= '0;
        r_err <= 1'b0;
        if (ctx_req && ctx_op != OP_NOP) begin
          if (w_swap) r_state <= S_DONE;
          else if (ctx_op == OP_PUSH && r_level < LW'(CTX_DEPTH)) r_state <= S_PUSH;
          else if (ctx_op == OP_POP && r_level != '0) r_state <= S_POP;
          else begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end
        end
      end
      S_PUSH, S_POP: begin
        r_idx <= r_idx + 1'b1;
        if (w_last) begin
          r_state <= S_DONE;
          r_level <= (r_state == S_PUSH) ? r_level + 1'b1 : r_level - 1'b1;
        end
      end
      default: r_state <= S_IDLE;
    endcase
endmodule
